// File: rtl/matrix_element_server_pkg.sv
// rtl/matrix_element_server_pkg.sv - shared constants, state enum and row-major index helper
package matrix_pkg;

    localparam int DATA_W = 32;
    localparam int N      = 5;
    localparam int DEPTH  = N * N;
    localparam int ADDR_W = 5;

    // Address-width copies so comparisons against the index ports stay width-matched
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } srv_state_e;

    // 1-based (row, col) to row-major storage index
    function automatic logic [ADDR_W-1:0] idx(input int row, input int col);
        return ADDR_W'((row - 1) * N + (col - 1));
    endfunction

endpackage

// File: rtl/matrix_element_server_if.sv
// rtl/matrix_element_server_if.sv - load stream and element read bus (parity_err under MATRIX_SERVER_PARITY_EN)
interface matrix_element_server_if;
    import matrix_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              clear;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              addr_err;
`ifdef MATRIX_SERVER_PARITY_EN
    logic              parity_err;

    modport slave  (input  in_valid, in_data, clear, address,
                    output in_ready, data_out, full, addr_err, parity_err);
    modport master (output in_valid, in_data, clear, address,
                    input  in_ready, data_out, full, addr_err, parity_err);
`else
    modport slave  (input  in_valid, in_data, clear, address,
                    output in_ready, data_out, full, addr_err);
    modport master (output in_valid, in_data, clear, address,
                    input  in_ready, data_out, full, addr_err);
`endif

endinterface

// File: rtl/matrix_element_server_ram.sv
// rtl/matrix_element_server_ram.sv - DEPTH-entry register array, one write port, one async read port
module mat_store_ram
    import matrix_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is never reset; contents only matter once a full load has completed
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Indices beyond the matrix read as zero instead of reaching past the array
    assign rdata_o = (raddr_i < DEPTH_A) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/matrix_element_server.sv
// rtl/matrix_element_server.sv - operand matrix store with registered reads (optional MATRIX_SERVER_PARITY_EN)
module matrix_element_server
    import matrix_pkg::*;
(
    input  logic clk,
    input  logic reset,
    matrix_element_server_if.slave bus
);

`ifdef MATRIX_SERVER_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    srv_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              addr_err_q, addr_err_d;
    logic              init_done_q;
    logic              wr_en;
    logic              addr_ok;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
`ifdef MATRIX_SERVER_PARITY_EN
    logic              parity_err_q, parity_err_d;
`endif

    assign addr_ok = bus.address < DEPTH_A;

`ifdef MATRIX_SERVER_PARITY_EN
    // Extra bit makes every stored word even parity
    assign wr_word = {^bus.in_data, bus.in_data};
`else
    assign wr_word = bus.in_data;
`endif

    mat_store_ram #(
        .WIDTH (MEM_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_cnt_q),
        .wdata_i (wr_word),
        .raddr_i (bus.address),
        .rdata_o (rd_word)
    );

    // State, write pointer and registered read outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD;
            wr_cnt_q     <= '0;
            data_out_q   <= '0;
            addr_err_q   <= 1'b0;
            init_done_q  <= 1'b0;
`ifdef MATRIX_SERVER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            data_out_q   <= data_out_d;
            addr_err_q   <= addr_err_d;
            init_done_q  <= 1'b1;
`ifdef MATRIX_SERVER_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next state: clear wins, LOAD fills row-major, FULL answers one read per clock
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        data_out_d   = '0;
        addr_err_d   = 1'b0;
        wr_en        = 1'b0;
`ifdef MATRIX_SERVER_PARITY_EN
        parity_err_d = 1'b0;
`endif
        if (bus.clear) begin
            state_d  = LOAD;
            wr_cnt_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid && bus.in_ready) begin
                        wr_en = 1'b1;
                        // Pointer parks on the last index; it never wraps
                        if (wr_cnt_q == LAST_IDX) begin
                            state_d = FULL;
                        end else begin
                            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                        end
                    end
                end
                FULL: begin
                    data_out_d = addr_ok ? rd_word[DATA_W-1:0] : '0;
                    addr_err_d = !addr_ok;
`ifdef MATRIX_SERVER_PARITY_EN
                    parity_err_d = addr_ok && (^rd_word);
`endif
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Ready is held low for the first clock after reset release
    assign bus.in_ready   = init_done_q && (state_q == LOAD);
    assign bus.full       = (state_q == FULL);
    assign bus.data_out   = data_out_q;
    assign bus.addr_err   = addr_err_q;
`ifdef MATRIX_SERVER_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_matrix_element_server.sv
// tb/tb_matrix_element_server.sv - randomized self-checking bench with a behavioural storage model
module tb_matrix_element_server;
    import matrix_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    matrix_element_server_if bus ();

    matrix_element_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: a count of accepted elements plus a plain array
    logic [31:0] m_mem [DEPTH];
    bit          m_corrupt [DEPTH];
    int          m_cnt   = 0;
    bit          m_armed = 1'b0;
    logic [31:0] m_dout  = '0;
    bit          m_err   = 1'b0;
    bit          m_perr  = 1'b0;
    int          m_a;

    logic [31:0] sent [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge, then every output compared just after it
    always @(posedge clk) begin
        if (!reset) begin
            m_cnt = 0; m_armed = 1'b0; m_dout = '0; m_err = 1'b0; m_perr = 1'b0;
        end else begin
            m_a = int'(bus.address);
            if (bus.clear) begin
                m_cnt = 0; m_dout = '0; m_err = 1'b0; m_perr = 1'b0;
            end else if (m_cnt == DEPTH) begin
                m_dout = '0; m_perr = 1'b0;
                m_err  = (m_a >= DEPTH);
                if (m_a < DEPTH) begin
                    m_dout = m_mem[m_a] ^ (m_corrupt[m_a] ? 32'h80 : 32'h0);
                    m_perr = m_corrupt[m_a];
                end
            end else begin
                m_dout = '0; m_err = 1'b0; m_perr = 1'b0;
                if (bus.in_valid && m_armed) begin
                    m_mem[m_cnt]     = bus.in_data;
                    m_corrupt[m_cnt] = 1'b0;
                    m_cnt++;
                end
            end
            m_armed = 1'b1;
        end
        #1;
        check("cyc_in_ready", bus.in_ready, m_armed && (m_cnt < DEPTH));
        check("cyc_full", bus.full, m_cnt == DEPTH);
        check("cyc_data_out", bus.data_out, m_dout);
        check("cyc_addr_err", bus.addr_err, m_err);
`ifdef MATRIX_SERVER_PARITY_EN
        check("cyc_parity_err", bus.parity_err, m_perr);
`endif
    end

    // Offer sent[0..count-1]; an element advances only when valid meets ready
    task automatic load(input bit gaps, input int count);
        int k = 0;
        int guard = 0;
        bit v;
        while (k < count && guard < 400) begin
            @(negedge clk);
            guard++;
            v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = sent[k];
            if (v && bus.in_ready) k++;
        end
        if (k < count) begin
            tests++; fails++;
            $display("FAIL load_timeout: got %0d accepted expected %0d", k, count);
        end
        @(posedge clk); #2;
        if (count == DEPTH) begin
            check("load_full", bus.full, 1);
            check("load_in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp_d, input bit exp_e);
        @(negedge clk);
        bus.address = a;
        @(posedge clk); #2;
        check($sformatf("rd_data@%0d", a), bus.data_out, exp_d);
        check($sformatf("rd_err@%0d", a), bus.addr_err, exp_e);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk); #2;
        check("clear_full", bus.full, 0);
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic readback_all();
        for (int r = 1; r <= N; r++)
            for (int c = 1; c <= N; c++)
                rd(idx(r, c), sent[(r - 1) * N + (c - 1)], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.clear = 1'b0; bus.address = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Sequential load, fixed reads
        for (int i = 0; i < DEPTH; i++) sent[i] = 32'(i + 1);
        load(1'b0, DEPTH);
        rd(idx(1, 1), 32'h0000_0001, 1'b0);
        rd(idx(3, 3), 32'h0000_000D, 1'b0);
        rd(idx(5, 5), 32'h0000_0019, 1'b0);

        // Gappy load, extra beats after full must be ignored
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) sent[i] = $urandom;
        load(1'b1, DEPTH);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hBAD0_0000 + 32'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        readback_all();

        // Out-of-range reads
        rd(5'd25, 32'h0, 1'b1);
        rd(5'd31, 32'h0, 1'b1);
        rd(5'd3, sent[3], 1'b0);

        // Clear with a same-cycle write, in FULL and again in LOAD
        @(negedge clk);
        bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        check("clr_full", bus.full, 0);
        check("clr_data", bus.data_out, 32'h0);
        @(posedge clk); #2;
        check("clr_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) sent[i] = 32'h100 + 32'(i);
        load(1'b0, DEPTH);
        rd(5'd0, 32'h0000_0100, 1'b0);

        // Reset during a partial load, then a fresh load
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) sent[i] = $urandom;
        load(1'b0, 10);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        check("rst_full", bus.full, 0);
        check("rst_data", bus.data_out, 32'h0);
        check("rst_ready", bus.in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) sent[i] = $urandom;
        load(1'b1, DEPTH);
        readback_all();

        // Reset while reading takes effect without waiting for a clock
        rd(5'd7, sent[7], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_full", bus.full, 0);
        check("async_data", bus.data_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Random traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.address  = ADDR_W'($urandom_range(0, 31));
            bus.in_valid = bit'($urandom_range(0, 1));
            bus.in_data  = $urandom;
            bus.clear    = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        bus.clear = 1'b0; bus.in_valid = 1'b0;

`ifdef MATRIX_SERVER_PARITY_EN
        // Flip one stored bit and expect a single parity pulse on that read
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) sent[i] = $urandom;
        load(1'b0, DEPTH);
        @(negedge clk);
        dut.u_ram.mem_q[4][7] = ~dut.u_ram.mem_q[4][7];
        m_corrupt[4] = 1'b1;
        rd(5'd4, sent[4] ^ 32'h80, 1'b0);
        check("par_err@4", bus.parity_err, 1);
        rd(5'd5, sent[5], 1'b0);
        check("par_err@5", bus.parity_err, 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
